// File: rtl/delay_line_var_pkg.sv
// Shared widths, saturation helper and sample type for the delay-line slice of the filter chain.
package delay_line_var_pkg;

  localparam int unsigned SAMPLE_W = 8;
  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned dly_w(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // History count saturates once every slot of the ring has been written.
  function automatic int unsigned fill_sat(input int unsigned max_delay);
    return max_delay;
  endfunction

endpackage

// File: rtl/delay_line_var_if.sv
// Sample-stream bus of the variable delay line: strobe, flush, delay select, data in/out.
interface delay_line_var_if import delay_line_var_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DELAY = 16
);
  localparam int unsigned DLY_W = dly_w(MAX_DELAY);

  logic             i_ce;
  logic             i_flush;
  logic [DLY_W-1:0] i_delay;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_clamp;

  modport master (output i_ce, i_flush, i_delay, i_data,
                  input  o_data, o_valid, o_clamp);
  modport slave  (input  i_ce, i_flush, i_delay, i_data,
                  output o_data, o_valid, o_clamp);
endinterface

// File: rtl/delay_line_var_ring_buf.sv
// Ring buffer: DEPTH x WIDTH registers, one write port with wrapping pointer, async read (old data).
module delay_line_var_ring_buf import delay_line_var_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [PTR_W-1:0] o_wptr,
  output logic [WIDTH-1:0] o_rdata
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_waddr;

  // A clear in the same cycle as a write restarts the history at slot 0.
  assign w_waddr = i_clear ? '0 : r_ptr;
  assign o_wptr  = w_waddr;
  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[w_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_ptr <= '0;
    else if (i_we)    r_ptr <= (w_waddr == LAST) ? '0 : w_waddr + 1'b1;
    else if (i_clear) r_ptr <= '0;
  end
endmodule

// File: rtl/delay_line_var.sv
// Runtime-programmable sample delay line: fill tracking, delay clamp, modular read address, output regs.
module delay_line_var import delay_line_var_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DELAY = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  delay_line_var_if.slave  bus
);
  localparam int unsigned PTR_W = ptr_w(MAX_DELAY);
  localparam int unsigned DLY_W = dly_w(MAX_DELAY);
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W-1:0] SAT_D = DLY_W'(fill_sat(MAX_DELAY));
  localparam logic [DLY_W:0]   MAX_X = (DLY_W + 1)'(MAX_DELAY);

  logic [DLY_W-1:0] r_fill;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_clamp;

  logic [DLY_W-1:0] w_de;
  logic [DLY_W-1:0] w_fill;
  logic [PTR_W-1:0] w_wptr;
  logic [PTR_W-1:0] w_raddr;
  logic [DLY_W:0]   w_ptr_x;
  logic [DLY_W:0]   w_de_x;
  logic [DLY_W:0]   w_raddr_x;
  logic [WIDTH-1:0] w_rdata;
  logic             w_hit;

  delay_line_var_ring_buf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .PTR_W (PTR_W)
  ) u_ring (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (bus.i_ce),
    .i_clear (bus.i_flush),
    .i_wdata (bus.i_data),
    .i_raddr (w_raddr),
    .o_wptr  (w_wptr),
    .o_rdata (w_rdata)
  );

  assign w_de   = (bus.i_delay > MAX_D) ? MAX_D : bus.i_delay;
  assign w_fill = bus.i_flush ? '0 : r_fill;
  assign w_hit  = (w_fill >= w_de);

  // Subtract-with-wrap for arbitrary depth: add MAX_DELAY back when the delay reaches past slot 0.
  assign w_ptr_x   = {{(DLY_W + 1 - PTR_W){1'b0}}, w_wptr};
  assign w_de_x    = {1'b0, w_de};
  assign w_raddr_x = (w_de_x > w_ptr_x) ? (w_ptr_x + MAX_X - w_de_x) : (w_ptr_x - w_de_x);
  assign w_raddr   = w_raddr_x[PTR_W-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_clamp <= 1'b0;
    end else if (bus.i_ce) begin
      r_fill  <= (w_fill < SAT_D) ? w_fill + 1'b1 : w_fill;
      r_valid <= w_hit;
      r_data  <= !w_hit ? '0 : (w_de == '0) ? bus.i_data : w_rdata;
      r_clamp <= (bus.i_delay > MAX_D);
    end else begin
      r_valid <= 1'b0;
      if (bus.i_flush) begin
        r_fill <= '0;
        r_data <= '0;
      end
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_clamp = r_clamp;
endmodule

// File: tb/tb_delay_line_var.sv
// Randomized and directed bench for delay_line_var against a history-queue reference model.
module tb_delay_line_var;
  import delay_line_var_pkg::*;

  localparam int unsigned MAXD = 16;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  delay_line_var_if #(.WIDTH(8), .MAX_DELAY(MAXD)) bus ();

  delay_line_var #(.WIDTH(8), .MAX_DELAY(MAXD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: last MAXD accepted samples since reset/flush, oldest first.
  sample_t     hist [$];
  sample_t     m_data;
  logic        m_valid;
  logic        m_clamp;
  int unsigned beat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s beat=%0d got=%0h exp=%0h", tag, beat, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_data"},  32'(bus.o_data),  32'(m_data));
    check({tag, "_valid"}, 32'(bus.o_valid), 32'(m_valid));
    check({tag, "_clamp"}, 32'(bus.o_clamp), 32'(m_clamp));
  endtask

  task automatic step(input string tag, input bit ce, input bit fl, input int unsigned d, input sample_t x);
    int unsigned de;
    int unsigned n;
    bus.i_ce    = ce;
    bus.i_flush = fl;
    bus.i_delay = 5'(d);
    bus.i_data  = x;
    @(posedge clk);
    if (fl) begin
      hist.delete();
      beat = 0;
    end
    if (ce) begin
      de      = (d > MAXD) ? MAXD : d;
      m_clamp = (d > MAXD);
      n       = hist.size();
      if (n >= de) begin
        m_valid = 1'b1;
        m_data  = (de == 0) ? x : hist[n - de];
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
      end
      hist.push_back(x);
      if (hist.size() > MAXD) void'(hist.pop_front());
    end else begin
      m_valid = 1'b0;
      if (fl) m_data = '0;
    end
    #1;
    check_outs(tag);
    if (ce) beat++;
    bus.i_ce    = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  task automatic model_reset();
    hist.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_clamp = 1'b0;
    beat    = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    bus.i_ce    = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_delay = '0;
    bus.i_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_outs("reset");

    for (int i = 0; i < 12; i++) step("d4", 1'b1, 1'b0, 4, sample_t'(i + 1));

    step("flush", 1'b0, 1'b1, 0, '0);
    for (int i = 0; i < 6; i++) step("d0", 1'b1, 1'b0, 0, sample_t'(i + 1));
    step("flush", 1'b0, 1'b1, 16, '0);
    for (int i = 0; i < 40; i++) step("d16", 1'b1, 1'b0, 16, sample_t'(i + 1));

    step("flush", 1'b0, 1'b1, 2, '0);
    for (int i = 0; i < 12; i++) begin
      step("ce3", 1'b1, 1'b0, 2, sample_t'(8'h40 + i));
      step("ce3_idle", 1'b0, 1'b0, 2, 8'hEE);
      step("ce3_idle", 1'b0, 1'b0, 2, 8'hDD);
    end

    for (int i = 0; i < 20; i++) step("d20", 1'b1, 1'b0, 20, sample_t'(8'h80 + i));
    for (int i = 0; i < 6; i++) step("d3", 1'b1, 1'b0, 3, sample_t'(8'hA0 + i));

    step("flush", 1'b0, 1'b1, 3, '0);
    for (int i = 0; i < 10; i++) step("d3b", 1'b1, 1'b0, 3, sample_t'(8'h10 + i));
    for (int i = 0; i < 4; i++) step("d8", 1'b1, 1'b0, 8, sample_t'(8'h20 + i));
    step("flush_ce", 1'b1, 1'b1, 3, 8'h55);
    for (int i = 0; i < 5; i++) step("post_flush", 1'b1, 1'b0, 3, sample_t'(8'h60 + i));
    step("flush_ce0", 1'b1, 1'b1, 0, 8'h77);

    for (int i = 0; i < 800; i++) begin
      step("rand",
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16),
           sample_t'($urandom));
    end

    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 20, sample_t'(8'hC0 + i));
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) step("d1", 1'b1, 1'b0, 1, sample_t'(8'hF0 + i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
